mem_access_ctrl: RTL

Memory-stage access controller that sequences data-memory transactions for the RV32I pipeline. Sits after the EX/MEM pipeline register: it consumes the registered memory-stage control (enable, load/store, funct3), address and store data, drives a request/ready handshake to data memory and stalls the front of the pipeline until the access completes. It returns the load result byte-aligned and sign- or zero-extended for the write-back mux, and aborts hung accesses with a timeout.

---
 rtl/mem_access_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: one data-memory transaction per memory instruction,
// pipeline stall, load formatting and timeout abort. Optional feature macro: MEM_MISALIGN_TRAP_EN.
module mem_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        M_endmem,
    input  logic        M_load_store,
    input  logic [2:0]  M_funct3,
    input  logic [31:0] M_addr,
    input  logic [31:0] M_wdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic [31:0] M_rdata,
    output logic        rdata_valid,
    output logic        bus_err,
    output logic        misalign_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0] state;
    logic [7:0] cnt;
    logic [2:0] funct3_q;
    logic [1:0] addr_lo_q;

    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b00:   return 4'b0001 << lo;
            2'b01:   return 4'b0011 << {lo[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] format_load(input logic [2:0] f3, input logic [1:0] lo,
                                                input logic [31:0] rd);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = rd[{lo, 3'b000} +: 8];
        h = rd[{lo[1], 4'b0000} +: 16];
        case (f3[1:0])
            2'b00:   return f3[2] ? {24'd0, b} : 32'(b);
            2'b01:   return f3[2] ? {16'd0, h} : 32'(h);
            default: return rd;
        endcase
    endfunction

    // Stall covers the IDLE cycle that accepts the instruction plus all ACCESS cycles.
    assign mem_stall = (state == S_ACCESS) || ((state == S_IDLE) && M_endmem);

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_c;

    always_comb begin
        case (M_funct3[1:0])
            2'b00:   misalign_c = 1'b0;
            2'b01:   misalign_c = M_addr[0];
            default: misalign_c = |M_addr[1:0];
        endcase
    end
`else
    assign misalign_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= 8'd0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= 32'd0;
            dmem_be     <= 4'd0;
            dmem_wdata  <= 32'd0;
            M_rdata     <= 32'd0;
            rdata_valid <= 1'b0;
            bus_err     <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_err <= 1'b0;
`endif
        end else begin
            rdata_valid <= 1'b0;
            bus_err     <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_err <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (M_endmem) begin
`ifdef MEM_MISALIGN_TRAP_EN
                        if (misalign_c) begin
                            state        <= S_DONE;
                            misalign_err <= 1'b1;
                            M_rdata      <= 32'd0;
                        end else
`endif
                        begin
                            state      <= S_ACCESS;
                            dmem_req   <= 1'b1;
                            dmem_we    <= M_load_store;
                            dmem_addr  <= {M_addr[31:2], 2'b00};
                            dmem_be    <= lane_be(M_funct3, M_addr[1:0]);
                            dmem_wdata <= lane_wdata(M_funct3, M_wdata);
                            funct3_q   <= M_funct3;
                            addr_lo_q  <= M_addr[1:0];
                            cnt        <= 8'd0;
                        end
                    end
                end
                // Ready wins over timeout when both happen in the last allowed cycle.
                S_ACCESS: begin
                    if (dmem_ready) begin
                        state    <= S_DONE;
                        dmem_req <= 1'b0;
                        if (!dmem_we) begin
                            M_rdata     <= format_load(funct3_q, addr_lo_q, dmem_rdata);
                            rdata_valid <= 1'b1;
                        end
                    end else if (cnt == CNT_LAST) begin
                        state    <= S_DONE;
                        dmem_req <= 1'b0;
                        M_rdata  <= 32'd0;
                        bus_err  <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
